// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the multicycle MIPS control FSM and its datapath.
// master = controller (drives enables/selects), slave = datapath (drives opcode/mem_ready).
interface mips_multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       sign_extend;
  logic [3:0] state;
  logic       stall_err;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, sign_extend, state, stall_err
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_src, sign_extend, state, stall_err
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS32 control FSM: 3-5 cycles per instruction plus one per memory wait.
// Outputs decode from registered state; FETCH/MEMRD/MEMWR hold until mem_ready.
module mips_multicycle_control #(
  parameter int unsigned FETCH_WAIT_MAX = 0
) (
  input logic                      clk,
  input logic                      reset,
  mips_multicycle_control_if.master ctl
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2, MEMRD = 4'd3,
    MEMWB   = 4'd4,  MEMWR  = 4'd5,  EXEC   = 4'd6, ALUWB = 4'd7,
    BRANCH  = 4'd8,  IMMEXEC = 4'd9, IMMWB  = 4'd10, JUMP = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [15:0] WAIT_MAX = 16'(FETCH_WAIT_MAX);

  logic [3:0]  state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [15:0] wait_cnt_q, wait_cnt_d;
  logic        stall_err_q, stall_err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      op_q        <= '0;
      wait_cnt_q  <= '0;
      stall_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_err_q <= stall_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    wait_cnt_d  = wait_cnt_q;
    stall_err_d = stall_err_q;
    case (state_q)
      FETCH: begin
        // Counter measures the wait of the current fetch only; it saturates.
        if (WAIT_MAX != 16'd0 && wait_cnt_q == WAIT_MAX) stall_err_d = 1'b1;
        if (ctl.mem_ready) begin
          state_d    = DECODE;
          wait_cnt_d = '0;
        end else if (wait_cnt_q != 16'hFFFF) begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end
      end
      DECODE: begin
        op_d = ctl.opcode;
        case (ctl.opcode)
          OP_LW, OP_SW:                      state_d = MEMADR;
          OP_RTYPE:                          state_d = EXEC;
          OP_BEQ:                            state_d = BRANCH;
          OP_J:                              state_d = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = IMMEXEC;
          default:                           state_d = FETCH;
        endcase
      end
      MEMADR:  state_d = (op_q == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   state_d = ctl.mem_ready ? MEMWB : MEMRD;
      MEMWR:   state_d = ctl.mem_ready ? FETCH : MEMWR;
      EXEC:    state_d = ALUWB;
      IMMEXEC: state_d = IMMWB;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    ctl.pc_write      = 1'b0;
    ctl.pc_write_cond = 1'b0;
    ctl.iord          = 1'b0;
    ctl.mem_read      = 1'b0;
    ctl.mem_write     = 1'b0;
    ctl.ir_write      = 1'b0;
    ctl.mem_to_reg    = 1'b0;
    ctl.reg_dst       = 1'b0;
    ctl.reg_write     = 1'b0;
    ctl.alu_src_a     = 1'b0;
    ctl.alu_src_b     = 2'b00;
    ctl.alu_op        = 2'b00;
    ctl.pc_src        = 2'b00;
    ctl.sign_extend   = 1'b1;
    case (state_q)
      FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = 2'b01;
        ctl.ir_write  = ctl.mem_ready;
        ctl.pc_write  = ctl.mem_ready;
      end
      DECODE: ctl.alu_src_b = 2'b11;
      MEMADR: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = 2'b10;
      end
      MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
      end
      MEMWB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = 1'b1;
      end
      MEMWR: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
      end
      EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_op    = 2'b10;
      end
      ALUWB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
      end
      BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_op        = 2'b01;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_src        = 2'b01;
      end
      IMMEXEC: begin
        // andi/ori take a zero-extended immediate; addi/slti sign-extend.
        ctl.alu_src_a   = 1'b1;
        ctl.alu_src_b   = 2'b10;
        ctl.alu_op      = (op_q == OP_ADDI) ? 2'b00 : 2'b11;
        ctl.sign_extend = !(op_q == OP_ANDI || op_q == OP_ORI);
      end
      IMMWB:  ctl.reg_write = 1'b1;
      JUMP: begin
        ctl.pc_write = 1'b1;
        ctl.pc_src   = 2'b10;
      end
      default: ;
    endcase
  end

  assign ctl.state     = state_q;
  assign ctl.stall_err = stall_err_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed-vector bench: each cycle's expected state/controls are queued; a negedge monitor compares.
module tb_mips_multicycle_control;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] JMP = 6'b000010, ADDI = 6'b001000, ANDI = 6'b001100, ORI = 6'b001101;
  localparam logic [5:0] UND = 6'b111111;

  typedef struct packed {
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       sign_extend, stall_err;
  } ctl_t;

  typedef struct packed {
    logic [3:0] state;
    ctl_t       ctl;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t exp_q[$];

  mips_multicycle_control_if bus();

  mips_multicycle_control #(.FETCH_WAIT_MAX(2)) dut (
    .clk   (clk),
    .reset (reset),
    .ctl   (bus)
  );

  always #5 clk = ~clk;

  // Control values required in each state, written from the state table.
  function automatic ctl_t expect_ctl(input logic [3:0] st, input logic [5:0] op,
                                      input logic mr, input logic stall);
    ctl_t c;
    c = '0;
    c.sign_extend = 1'b1;
    c.stall_err   = stall;
    case (st)
      4'd0:  begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.ir_write = mr; c.pc_write = mr; end
      4'd1:  c.alu_src_b = 2'b11;
      4'd2:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      4'd3:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
      4'd4:  begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
      4'd5:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
      4'd6:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      4'd7:  begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
      4'd8:  begin c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_src = 2'b01; end
      4'd9:  begin
        c.alu_src_a   = 1'b1;
        c.alu_src_b   = 2'b10;
        c.alu_op      = (op == ADDI) ? 2'b00 : 2'b11;
        c.sign_extend = (op == ANDI || op == ORI) ? 1'b0 : 1'b1;
      end
      4'd10: c.reg_write = 1'b1;
      4'd11: begin c.pc_write = 1'b1; c.pc_src = 2'b10; end
      default: ;
    endcase
    return c;
  endfunction

  // One clock of stimulus; est is the state the DUT must be in during this cycle.
  task automatic step(input logic rst, input logic [5:0] opc, input logic mr,
                      input logic [3:0] est, input logic [5:0] iop, input logic stall);
    exp_t e;
    reset         = rst;
    bus.opcode    = opc;
    bus.mem_ready = mr;
    e.state = est;
    e.ctl   = expect_ctl(est, iop, mr, stall);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    ctl_t act;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      act = '{bus.pc_write, bus.pc_write_cond, bus.iord, bus.mem_read, bus.mem_write,
              bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
              bus.alu_src_b, bus.alu_op, bus.pc_src, bus.sign_extend, bus.stall_err};
      n_checks++;
      if (bus.state !== e.state) begin
        n_fail++;
        $display("FAIL state cyc=%0d: got %0d, want %0d", cyc, bus.state, e.state);
      end
      n_checks++;
      if (act !== e.ctl) begin
        n_fail++;
        $display("FAIL ctl cyc=%0d state=%0d: got %b, want %b", cyc, e.state, act, e.ctl);
      end
    end
  end

  initial begin
    reset         = 1'b1;
    bus.opcode    = '0;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    // Reset held: FETCH, nothing sticky.
    step(1, LW, 0, 0, LW, 0);
    // lw, zero-wait: 0,1,2,3,4
    step(0, LW, 1, 0, LW, 0);
    step(0, LW, 1, 1, LW, 0);
    step(0, LW, 1, 2, LW, 0);
    step(0, LW, 1, 3, LW, 0);
    step(0, LW, 1, 4, LW, 0);
    // ori then addi
    step(0, ORI, 1, 0, ORI, 0);
    step(0, ORI, 1, 1, ORI, 0);
    step(0, ORI, 1, 9, ORI, 0);
    step(0, ORI, 1, 10, ORI, 0);
    step(0, ADDI, 1, 0, ADDI, 0);
    step(0, ADDI, 1, 1, ADDI, 0);
    step(0, ADDI, 1, 9, ADDI, 0);
    step(0, ADDI, 1, 10, ADDI, 0);
    // sw with three wait cycles in MEMWR
    step(0, SW, 1, 0, SW, 0);
    step(0, SW, 1, 1, SW, 0);
    step(0, SW, 1, 2, SW, 0);
    step(0, SW, 0, 5, SW, 0);
    step(0, SW, 0, 5, SW, 0);
    step(0, SW, 0, 5, SW, 0);
    step(0, SW, 1, 5, SW, 0);
    // FETCH stalled two cycles, then j; stall_err becomes sticky
    step(0, JMP, 0, 0, JMP, 0);
    step(0, JMP, 0, 0, JMP, 0);
    step(0, JMP, 1, 0, JMP, 0);
    step(0, JMP, 1, 1, JMP, 1);
    step(0, JMP, 1, 11, JMP, 1);
    // undefined opcode is a NOP
    step(0, UND, 1, 0, UND, 1);
    step(0, UND, 1, 1, UND, 1);
    // beq
    step(0, BEQ, 1, 0, BEQ, 1);
    step(0, BEQ, 1, 1, BEQ, 1);
    step(0, BEQ, 1, 8, BEQ, 1);
    // andi
    step(0, ANDI, 1, 0, ANDI, 1);
    step(0, ANDI, 1, 1, ANDI, 1);
    step(0, ANDI, 1, 9, ANDI, 1);
    step(0, ANDI, 1, 10, ANDI, 1);
    // lw abandoned by reset in MEMRD
    step(0, LW, 1, 0, LW, 1);
    step(0, LW, 1, 1, LW, 1);
    step(0, LW, 1, 2, LW, 1);
    step(1, LW, 0, 3, LW, 1);
    // R-type; opcode changes during EXEC
    step(0, RT, 1, 0, RT, 0);
    step(0, RT, 1, 1, RT, 0);
    step(0, LW, 1, 6, RT, 0);
    step(0, LW, 1, 7, RT, 0);
    step(0, LW, 1, 0, LW, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
